// File: rtl/shift_xfer_ctrl.sv
// Command-driven serial transfer engine: loads a word, shifts it out over
// ser_out while capturing ser_in, then returns the register on a response port.
module shift_xfer_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_en,
  input  logic             ser_in,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_eff;
  logic             dir_q;
  logic             accept;
  logic             last_shift;

  assign accept     = (state == IDLE) && cmd_valid;
  assign last_shift = (count == len_q - LEN_W'(1));
  // Zero or oversized lengths collapse to a full-width transfer.
  assign len_eff    = ((cmd_len == '0) || (cmd_len > WIDTH_L)) ? WIDTH_L : cmd_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of statement or block order.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output and next-state gets a default first; a path that
    // forgets to assign one would otherwise infer a latch.
    state_nxt = state;
    cmd_ready = 1'b0;
    ser_en    = 1'b0;
    ser_out   = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        ser_en  = 1'b1;
        ser_out = dir_q ? sr[0] : sr[WIDTH-1];
        if (abort)           state_nxt = IDLE;
        else if (last_shift) state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = sr;
        // abort and rsp_ready both leave RESP; abort simply suppresses the response.
        if (abort || rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shift register is ordinary flops, not a RAM, so it is cleared
      // with the rest of the datapath and cannot surface stale data after reset.
      sr    <= '0;
      count <= '0;
      dir_q <= 1'b0;
      len_q <= '0;
    end else if (accept) begin
      sr    <= cmd_data;
      dir_q <= cmd_dir;
      len_q <= len_eff;
      count <= '0;
    end else if (state == SHIFT && !abort) begin
      sr    <= dir_q ? {ser_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], ser_in};
      count <= count + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Scoreboard bench for shift_xfer_ctrl: expected serial bits and responses are
// queued at command time and compared as the DUT produces them.
module tb_shift_xfer_ctrl;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] cmd_data;
  logic             abort;
  logic             ser_out;
  logic             ser_en;
  logic             ser_in;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  logic             loop_en;
  logic             sin_val;

  int checks = 0;
  int errors = 0;
  int ser_cycles = 0;

  logic             ser_q[$];
  logic [WIDTH-1:0] rsp_q[$];

  always #5 clk = ~clk;

  assign ser_in = loop_en ? ser_out : sin_val;

  shift_xfer_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .ser_out   (ser_out),
    .ser_en    (ser_en),
    .ser_in    (ser_in),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  // Serial monitor: every ser_en cycle consumes one expected bit.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (ser_en) begin
        ser_cycles++;
        if (ser_q.size() == 0) begin
          errors++;
          $display("FAIL ser_unexpected: ser_en=1 ser_out=%0b, no bit expected", ser_out);
        end else begin
          logic exp_bit;
          exp_bit = ser_q.pop_front();
          if (ser_out !== exp_bit) begin
            errors++;
            $display("FAIL ser_out: got %0b expected %0b (shift %0d)", ser_out, exp_bit, ser_cycles);
          end
        end
      end else if (ser_out !== 1'b0) begin
        errors++;
        $display("FAIL ser_out_idle: got %0b expected 0", ser_out);
      end
    end
  end

  // Reference model of one transfer; pushes the bit stream and final word.
  task automatic expect_xfer(input logic dir, input int len, input logic [WIDTH-1:0] data,
                             input logic sin, input logic loop_mode);
    logic [WIDTH-1:0] s;
    logic b, in_bit;
    int n;
    n = (len == 0 || len > WIDTH) ? WIDTH : len;
    s = data;
    for (int i = 0; i < n; i++) begin
      b      = dir ? s[0] : s[WIDTH-1];
      in_bit = loop_mode ? b : sin;
      s      = dir ? {in_bit, s[WIDTH-1:1]} : {s[WIDTH-2:0], in_bit};
      ser_q.push_back(b);
    end
    rsp_q.push_back(s);
  endtask

  // Called away from the rising edge; returns #1 after the accept edge.
  task automatic send_cmd(input logic dir, input int len, input logic [WIDTH-1:0] data);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_before_send: got %0b expected 1", cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_len    = LEN_W'(len);
    cmd_data   = data;
    ser_cycles = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid, checks latency and the scoreboard word.
  task automatic wait_rsp(input int exp_lat, input string name);
    int n;
    logic got;
    logic [WIDTH-1:0] exp_w;
    got = 1'b0;
    n   = 0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_rsp_timeout: rsp_valid never rose within 40 cycles", name);
      return;
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges expected %0d", name, n, exp_lat);
    end
    checks++;
    if (ser_cycles != exp_lat) begin
      errors++;
      $display("FAIL %s_ser_cycles: got %0d expected %0d", name, ser_cycles, exp_lat);
    end
    exp_w = rsp_q.size() ? rsp_q.pop_front() : 'x;
    checks++;
    if (rsp_data !== exp_w) begin
      errors++;
      $display("FAIL %s_rsp_data: got 0x%02h expected 0x%02h", name, rsp_data, exp_w);
    end
  endtask

  // Called at a negedge in RESP; completes the handshake and checks IDLE.
  task automatic release_rsp(input string name);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL %s_release: cmd_ready=%0b rsp_valid=%0b busy=%0b rsp_data=0x%02h expected 1,0,0,0x00",
               name, cmd_ready, rsp_valid, busy, rsp_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0; cmd_data = '0;
    abort = 1'b0; rsp_ready = 1'b0; loop_en = 1'b0; sin_val = 1'b0;
    #12;
    checks++;
    if (cmd_ready !== 1'b1 || ser_en !== 1'b0 || ser_out !== 1'b0 || busy !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cmd_ready=%0b ser_en=%0b ser_out=%0b busy=%0b rsp_valid=%0b rsp_data=0x%02h expected 1,0,0,0,0,0x00",
               cmd_ready, ser_en, ser_out, busy, rsp_valid, rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback_msb();
    loop_en = 1'b1;
    expect_xfer(1'b0, 8, 8'hA5, 1'b0, 1'b1);
    send_cmd(1'b0, 8, 8'hA5);
    wait_rsp(8, "loop_msb");
    checks++;
    if (rsp_data !== 8'hA5) begin
      errors++;
      $display("FAIL loop_msb_literal: got 0x%02h expected 0xa5", rsp_data);
    end
    release_rsp("loop_msb");
    loop_en = 1'b0;
  endtask

  task automatic test_lsb_first();
    sin_val = 1'b0;
    expect_xfer(1'b1, 8, 8'h1E, 1'b0, 1'b0);
    send_cmd(1'b1, 8, 8'h1E);
    wait_rsp(8, "lsb_first");
    checks++;
    if (rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL lsb_first_literal: got 0x%02h expected 0x00", rsp_data);
    end
    release_rsp("lsb_first");
  endtask

  task automatic test_partial_len();
    sin_val = 1'b1;
    expect_xfer(1'b0, 3, 8'h1E, 1'b1, 1'b0);
    send_cmd(1'b0, 3, 8'h1E);
    wait_rsp(3, "len3");
    checks++;
    if (rsp_data !== 8'hF7) begin
      errors++;
      $display("FAIL len3_literal: got 0x%02h expected 0xf7", rsp_data);
    end
    release_rsp("len3");
    expect_xfer(1'b0, 0, 8'h1E, 1'b1, 1'b0);
    send_cmd(1'b0, 0, 8'h1E);
    wait_rsp(8, "len0");
    release_rsp("len0");
    // Oversized length also means a full-width transfer.
    sin_val = 1'b0;
    expect_xfer(1'b1, 12, 8'hC3, 1'b0, 1'b0);
    send_cmd(1'b1, 12, 8'hC3);
    wait_rsp(8, "len12");
    release_rsp("len12");
    expect_xfer(1'b1, 5, 8'h96, 1'b1, 1'b0);
    sin_val = 1'b1;
    send_cmd(1'b1, 5, 8'h96);
    wait_rsp(5, "len5_lsb");
    release_rsp("len5_lsb");
    sin_val = 1'b0;
  endtask

  task automatic test_rsp_stall();
    logic [WIDTH-1:0] held;
    expect_xfer(1'b0, 4, 8'h5A, 1'b0, 1'b0);
    send_cmd(1'b0, 4, 8'h5A);
    wait_rsp(4, "stall");
    held = rsp_data;
    cmd_valid = 1'b1;
    cmd_data  = 8'hFF;
    cmd_len   = 4'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: rsp_valid=%0b rsp_data=0x%02h cmd_ready=%0b busy=%0b expected 1,0x%02h,0,1",
                 i, rsp_valid, rsp_data, cmd_ready, busy, held);
      end
    end
    cmd_valid = 1'b0;
    release_rsp("stall");
  endtask

  task automatic test_abort();
    sin_val = 1'b0;
    expect_xfer(1'b0, 8, 8'hE1, 1'b0, 1'b0);
    send_cmd(1'b0, 8, 8'hE1);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (ser_en !== 1'b0 || cmd_ready !== 1'b1 || ser_cycles != 2) begin
      errors++;
      $display("FAIL abort_stop: ser_en=%0b cmd_ready=%0b ser_cycles=%0d expected 0,1,2",
               ser_en, cmd_ready, ser_cycles);
    end
    ser_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_rsp[%0d]: rsp_valid=%0b expected 0", i, rsp_valid);
      end
    end
    expect_xfer(1'b0, 8, 8'h3C, 1'b1, 1'b0);
    sin_val = 1'b1;
    send_cmd(1'b0, 8, 8'h3C);
    wait_rsp(8, "after_abort");
    // Abort in RESP wins over a simultaneous rsp_ready and drops the response.
    abort = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_resp: rsp_valid=%0b cmd_ready=%0b expected 0,1", rsp_valid, cmd_ready);
    end
    sin_val = 1'b0;
  endtask

  task automatic test_back_to_back_abort_idle();
    // abort in IDLE must not block a simultaneous command.
    abort = 1'b1;
    expect_xfer(1'b1, 6, 8'hB4, 1'b0, 1'b0);
    send_cmd(1'b1, 6, 8'hB4);
    abort = 1'b0;
    wait_rsp(6, "abort_idle");
    release_rsp("abort_idle");
    expect_xfer(1'b0, 2, 8'h81, 1'b0, 1'b0);
    send_cmd(1'b0, 2, 8'h81);
    wait_rsp(2, "back_to_back");
    release_rsp("back_to_back");
  endtask

  task automatic test_async_reset();
    expect_xfer(1'b0, 8, 8'hFF, 1'b0, 1'b0);
    send_cmd(1'b0, 8, 8'hFF);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (ser_en !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ser_en=%0b busy=%0b rsp_valid=%0b rsp_data=0x%02h cmd_ready=%0b expected 0,0,0,0x00,1",
               ser_en, busy, rsp_valid, rsp_data, cmd_ready);
    end
    ser_q.delete();
    rsp_q.delete();
    #13;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || ser_en !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset[%0d]: rsp_valid=%0b ser_en=%0b cmd_ready=%0b expected 0,0,1",
                 i, rsp_valid, ser_en, cmd_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback_msb();
    test_lsb_first();
    test_partial_len();
    test_rsp_stall();
    test_abort();
    test_back_to_back_abort_idle();
    test_async_reset();
    checks++;
    if (ser_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d bits and %0d words left", ser_q.size(), rsp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
